// File: rtl/phy_pkg.sv
// Shared definitions for the PCI PHY receive path: COM symbol, alignment
// FSM states and the sizing helper for the aligned-COM counter.
package phy_pkg;

    // Alignment / idle symbol
    localparam logic [7:0]  COM_DEFAULT   = 8'hBC;
    // Consecutive boundary-aligned COMs required before the link is active
    localparam int unsigned N_COM_DEFAULT = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    // Width of a counter that must hold 0..n inclusive
    function automatic int unsigned com_cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/shift_reg_1_8.sv
// Serial input history for the 1->8 receiver. next_byte is the byte that
// ends with the bit currently on data_in (MSB-first line order).
module shift_reg_1_8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] next_byte
);

    // Only the seven most recent bits are ever read back, so the oldest
    // stage of the conceptual 8-bit register is not stored.
    logic [6:0] sr;

    assign next_byte = {sr, data_in};

    // Shift one line bit in per clock; reset clears the history
    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else begin
            sr <= next_byte[6:0];
        end
    end

endmodule

// File: rtl/serial_paralelo_1_8.sv
// Serial-to-parallel receiver: hunts for COM, confirms N_COM aligned COMs,
// then delivers one byte every 8 clocks with valid/strobe flags.
// Optional feature macro: RESYNC_EN (in ACTIVE, a misaligned COM moves the
// byte boundary onto itself).
module serial_paralelo_1_8
    import phy_pkg::*;
#(
    parameter logic [7:0]  COM   = COM_DEFAULT,
    parameter int unsigned N_COM = N_COM_DEFAULT
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_stb,
    output logic       active
);

    localparam int unsigned     CW         = com_cnt_width(N_COM);
    localparam logic [CW-1:0]   COM_TARGET = CW'(N_COM);

    logic [7:0]    next_byte;
    state_t        state;
    logic [2:0]    cnt;
    logic [CW-1:0] com_cnt;

    shift_reg_1_8 u_shift_reg (
        .clk       (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .next_byte (next_byte)
    );

    // Alignment FSM, bit counter, COM counter and registered outputs
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state     <= SEARCH;
            cnt       <= '0;
            com_cnt   <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            byte_stb  <= 1'b0;
            active    <= 1'b0;
        end else begin
            byte_stb <= 1'b0;
            unique case (state)
                SEARCH: begin
                    if (next_byte == COM) begin
                        cnt     <= '0;
                        com_cnt <= CW'(1);
                        state   <= ALIGN;
                    end
                end

                ALIGN: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        if (next_byte == COM) begin
                            if (com_cnt != COM_TARGET) begin
                                com_cnt <= com_cnt + CW'(1);
                            end
                            if (com_cnt + CW'(1) == COM_TARGET) begin
                                state  <= ACTIVE;
                                active <= 1'b1;
                            end
                        end else begin
                            com_cnt <= '0;
                            state   <= SEARCH;
                        end
                    end
                end

                ACTIVE: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        data_out  <= next_byte;
                        valid_out <= (next_byte != COM);
                        byte_stb  <= 1'b1;
                    end
`ifdef RESYNC_EN
                    // Misaligned COM: the truncated byte is dropped and the
                    // next boundary lands 8 bits after this COM.
                    else if (next_byte == COM) begin
                        cnt <= '0;
                    end
`endif
                end

                default: begin
                    state <= SEARCH;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_paralelo_1_8.md
# serial_paralelo_1_8

Serial-to-parallel receiver stage of the PCI physical layer. It takes the 1-bit line stream at clk_32f, finds byte alignment by hunting for the COM symbol, and requires N_COM consecutive aligned COMs before declaring the link active. It then emits one 8-bit byte every 8 clocks with a valid flag, feeding the data_in/valid inputs of the downstream 8→32 demultiplexer.

## Interface
- COM, 8'hBC: alignment/idle symbol.
- N_COM, 4: consecutive aligned COMs required to enter ACTIVE (≥2).
- clk_32f  input  1  bit-rate clock; all logic on its posedge.
- reset  input  1  synchronous, active-high.
- data_in  input  1  serial bit, MSB of each byte first.
- data_out  output  8  last completed byte; held for 8 cycles.
- valid_out  output  1  1 when data_out holds a non-COM byte in ACTIVE; held with data_out.
- byte_stb  output  1  one-cycle pulse on each data_out/valid_out update.
- active  output  1  link aligned and delivering data.

## Operation
- Shift register sr[7:0] <= {sr[6:0], data_in} every cycle; next_byte = {sr[6:0], data_in}.
- Bit counter cnt[2:0], free-running 0..7 once aligned; byte boundary when cnt==7.
- States:
  - SEARCH (reset state): every cycle compare next_byte to COM. On match: cnt<=0, com_cnt<=1, go ALIGN.
  - ALIGN: at cnt==7: next_byte==COM → com_cnt++; if com_cnt+1==N_COM go ACTIVE and set active. next_byte!=COM → com_cnt<=0, go SEARCH (bit hunting resumes the following cycle).
  - ACTIVE: at cnt==7: data_out<=next_byte, valid_out<=(next_byte!=COM), byte_stb<=1. COM bytes in ACTIVE are idles: data_out still updated, valid_out=0.
- Without RESYNC_EN, ACTIVE is left only by reset.
- com_cnt width $clog2(N_COM+1), saturates at N_COM.
- Reset outputs: data_out=8'h00, valid_out=0, byte_stb=0, active=0; sr=0, cnt=0, com_cnt=0, state=SEARCH.

## Timing
- Latency: byte's last bit sampled at edge E → data_out/valid_out/byte_stb visible after E; byte_stb drops after E+1.
- Byte_stb period exactly 8 cycles in ACTIVE.
- active rises on the same edge that completes the N_COM-th aligned COM; first data byte appears 8 cycles later.
- Reset asserted mid-byte: all state cleared on that edge; alignment restarts from SEARCH; the partially received byte is discarded.
- Reset has priority over all other events.
- COM straddling a stale boundary during ALIGN is ignored; only boundary-aligned comparisons count.

## Configuration
- RESYNC_EN defined: in ACTIVE, if next_byte==COM while cnt!=7, cnt<=0 on that edge (boundary moves); active stays 1; no byte_stb for the truncated byte; subsequent bytes use the new boundary.
- RESYNC_EN undefined: misaligned COM patterns in ACTIVE are ignored; boundary fixed until reset.

## Structure
- Shared package phy_pkg: COM default constant, state enum (SEARCH, ALIGN, ACTIVE), and the width function for com_cnt.
- One sub-module natural: shift_reg_1_8 (sr plus next_byte tap); FSM, counters and output registers stay in the top.

## Test plan
- Reset held 3 cycles, then idle 0s → outputs all 0, state SEARCH, no byte_stb.
- Random 3-bit offset, then 4×BC, then EE FF FD CC → active rises on 4th BC; data_out EE,FF,FD,CC with valid_out=1, byte_stb every 8 cycles.
- 2×BC then 8'h55 then 4×BC → falls back to SEARCH after 55; active only after later 4 BCs.
- ACTIVE stream EE BC AA → data_out EE(v=1), BC(v=0), AA(v=1).
- Reset pulsed mid-byte during ACTIVE → outputs zero next cycle, realignment required.
- RESYNC_EN: in ACTIVE insert BC shifted by 3 bits → boundary moves, following 12 decodes correctly; without macro, bytes remain misaligned.
